// File: rtl/collision_event_arbiter.sv
// Collision event arbiter: captures per-frame collision pulses, banks them at startOfFrame,
// and presents them one at a time, highest priority first, over a valid/ack handshake.
module collision_event_arbiter #(
  parameter int GAP_CYCLES = 2
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       colBottom,
  input  logic       colFlipper,
  input  logic       colBumper,
  input  logic       colSpring,
  input  logic       colFrame,
  input  logic       colObstacleGood,
  input  logic       colObstacleBad,
  input  logic       evt_ack,
  output logic       evt_valid,
  output logic [2:0] evt_code,
  output logic [7:0] drop_count,
  output logic       overrun,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, PRESENT, GAP} stateT;

  localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES);

  logic [7:1] pulses;
  logic [7:1] cap;
  logic [7:1] disp;
  stateT      state;
  logic [3:0] gapCnt;

  // Bit index equals event code; code 1 (BOTTOM) has the highest priority.
  assign pulses = {colObstacleBad, colObstacleGood, colFrame, colSpring,
                   colBumper, colFlipper, colBottom};

  function automatic logic [2:0] firstCode(input logic [7:1] bank);
    firstCode = 3'd0;
    for (int i = 7; i >= 1; i--) begin
      if (bank[i]) firstCode = 3'(i);
    end
  endfunction

  function automatic logic [3:0] popCount(input logic [7:1] bank);
    popCount = 4'd0;
    for (int i = 1; i <= 7; i++) begin
      popCount = popCount + 4'(bank[i]);
    end
  endfunction

  logic       ackNow;
  logic       flushNow;
  logic       launchNow;
  logic       dropNow;
  logic [2:0] launchCode;
  logic [8:0] dropSum;
  logic [7:1] dispNext;
  stateT      stateNext;
  logic [3:0] gapNext;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path leaves one unassigned (no latch).
    ackNow     = (state == PRESENT) && evt_ack;
    flushNow   = ackNow && (evt_code == 3'd1);
    launchCode = firstCode(disp);
    launchNow  = (state == IDLE) && (disp != '0) && !startOfFrame;
    // A BOTTOM ack flushes the old bank, so those bits are not reported as drops.
    dropNow    = startOfFrame && (disp != '0) && !flushNow;
    dropSum    = {1'b0, drop_count} + 9'(popCount(disp));
    dispNext   = disp;
    stateNext  = state;
    gapNext    = gapCnt;

    if (startOfFrame)   dispNext = cap;
    else if (flushNow)  dispNext = '0;
    else if (launchNow) dispNext[launchCode] = 1'b0;

    case (state)
      IDLE: if (launchNow) stateNext = PRESENT;
      PRESENT: begin
        if (ackNow) begin
          if (GAP_CYCLES == 0) begin
            stateNext = IDLE;
          end else begin
            stateNext = GAP;
            gapNext   = GAP_LOAD;
          end
        end
      end
      GAP: begin
        if (gapCnt <= 4'd1) stateNext = IDLE;
        gapNext = gapCnt - 4'd1;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      cap        <= '0;
      disp       <= '0;
      state      <= IDLE;
      gapCnt     <= '0;
      evt_valid  <= 1'b0;
      evt_code   <= 3'd0;
      drop_count <= 8'd0;
      overrun    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      cap     <= startOfFrame ? pulses : (cap | pulses);
      disp    <= dispNext;
      state   <= stateNext;
      gapCnt  <= gapNext;
      busy    <= (dispNext != '0) || (stateNext != IDLE);
      overrun <= dropNow;
      if (dropNow) drop_count <= dropSum[8] ? 8'hFF : dropSum[7:0];
      if (launchNow) begin
        evt_valid <= 1'b1;
        evt_code  <= launchCode;
      end else if (ackNow) begin
        evt_valid <= 1'b0;
        evt_code  <= 3'd0;
      end
    end
  end

endmodule

// File: tb/tb_collision_event_arbiter.sv
// Scoreboard bench for collision_event_arbiter: two instances (gap 2 and gap 0) share the stimulus
// and are checked against a set/timestamp reference model.
module tb_collision_event_arbiter;

  localparam int HALF = 5;
  localparam int NDUT = 2;

  localparam bit [7:1] BOTTOM = 7'b0000001;
  localparam bit [7:1] FLIP   = 7'b0000010;
  localparam bit [7:1] BUMP   = 7'b0000100;
  localparam bit [7:1] SPRING = 7'b0001000;
  localparam bit [7:1] FRAME  = 7'b0010000;
  localparam bit [7:1] OGOOD  = 7'b0100000;
  localparam bit [7:1] OBAD   = 7'b1000000;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  logic startOfFrame = 1'b0;
  logic evt_ack = 1'b0;
  logic [7:1] pulses = '0;

  logic [NDUT-1:0]       evt_valid;
  logic [NDUT-1:0][2:0]  evt_code;
  logic [NDUT-1:0][7:0]  drop_count;
  logic [NDUT-1:0]       overrun;
  logic [NDUT-1:0]       busy;

  collision_event_arbiter #(.GAP_CYCLES(2)) u_gap2 (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .colBottom(pulses[1]), .colFlipper(pulses[2]), .colBumper(pulses[3]), .colSpring(pulses[4]),
    .colFrame(pulses[5]), .colObstacleGood(pulses[6]), .colObstacleBad(pulses[7]),
    .evt_ack(evt_ack), .evt_valid(evt_valid[0]), .evt_code(evt_code[0]),
    .drop_count(drop_count[0]), .overrun(overrun[0]), .busy(busy[0])
  );

  collision_event_arbiter #(.GAP_CYCLES(0)) u_gap0 (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .colBottom(pulses[1]), .colFlipper(pulses[2]), .colBumper(pulses[3]), .colSpring(pulses[4]),
    .colFrame(pulses[5]), .colObstacleGood(pulses[6]), .colObstacleBad(pulses[7]),
    .evt_ack(evt_ack), .evt_valid(evt_valid[1]), .evt_code(evt_code[1]),
    .drop_count(drop_count[1]), .overrun(overrun[1]), .busy(busy[1])
  );

  initial forever #HALF clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: pending sets, the in-flight code, and the first cycle the arbiter may launch again.
  typedef struct {
    bit [7:1] capSet;
    bit [7:1] dispSet;
    int       inFlight;
    int       idleFrom;
    int       drops;
    bit       overrunNow;
    bit       busyNow;
  } model_t;

  typedef struct {
    int dut;
    int cyc;
    bit valid;
    bit ovr;
    int drops;
    bit busy;
  } status_t;

  typedef struct {
    int dut;
    int code;
    int cyc;
  } event_t;

  model_t  mdl [NDUT];
  status_t statQ[$];
  event_t  evQ[$];
  int      cyc = 0;
  int      total = 0;
  int      bad = 0;

  function automatic int gapOf(input int k);
    return (k == 0) ? 2 : 0;
  endfunction

  task automatic check(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, actual, expected);
    end
  endtask

  function automatic int lowestCode(input bit [7:1] s);
    for (int i = 1; i <= 7; i++) if (s[i]) return i;
    return 0;
  endfunction

  function automatic void advance(input int k, input bit sof, input bit [7:1] p, input bit ack, input int c);
    bit acked;
    bit flush;
    int code;
    int sum;
    acked = (mdl[k].inFlight != 0) && ack;
    flush = acked && (mdl[k].inFlight == 1);
    mdl[k].overrunNow = 1'b0;
    if (sof) begin
      if (mdl[k].dispSet != 0 && !flush) begin
        sum = mdl[k].drops + $countones(mdl[k].dispSet);
        mdl[k].drops = (sum > 255) ? 255 : sum;
        mdl[k].overrunNow = 1'b1;
      end
      mdl[k].dispSet = mdl[k].capSet;
    end else if (flush) begin
      mdl[k].dispSet = '0;
    end else if (mdl[k].inFlight == 0 && c >= mdl[k].idleFrom && mdl[k].dispSet != 0) begin
      code = lowestCode(mdl[k].dispSet);
      mdl[k].dispSet[code] = 1'b0;
      mdl[k].inFlight = code;
      evQ.push_back('{dut: k, code: code, cyc: c + 1});
    end
    if (acked) begin
      mdl[k].inFlight = 0;
      mdl[k].idleFrom = c + 1 + gapOf(k);
    end
    mdl[k].capSet = sof ? p : (mdl[k].capSet | p);
    mdl[k].busyNow = (mdl[k].dispSet != 0) || (mdl[k].inFlight != 0) || (c + 1 < mdl[k].idleFrom);
  endfunction

  task automatic step(input bit sof, input bit [7:1] p, input bit ack);
    @(posedge clk);
    #1;
    cyc++;
    startOfFrame = sof;
    pulses       = p;
    evt_ack      = ack;
    for (int k = 0; k < NDUT; k++) begin
      statQ.push_back('{dut: k, cyc: cyc, valid: (mdl[k].inFlight != 0), ovr: mdl[k].overrunNow,
                        drops: mdl[k].drops, busy: mdl[k].busyNow});
      advance(k, sof, p, ack, cyc);
    end
  endtask

  task automatic idle(input int n, input bit ack);
    for (int i = 0; i < n; i++) step(1'b0, '0, ack);
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    cyc++;
    startOfFrame = 1'b0;
    pulses       = '0;
    evt_ack      = 1'b0;
    resetN       = 1'b0;
    #1;
    for (int k = 0; k < NDUT; k++) begin
      check($sformatf("rst_valid d%0d", k), int'(evt_valid[k]), 0);
      check($sformatf("rst_code d%0d", k), int'(evt_code[k]), 0);
      check($sformatf("rst_drops d%0d", k), int'(drop_count[k]), 0);
      check($sformatf("rst_overrun d%0d", k), int'(overrun[k]), 0);
      check($sformatf("rst_busy d%0d", k), int'(busy[k]), 0);
      mdl[k] = '{default: 0};
    end
    evQ.delete();
    statQ.delete();
    repeat (2) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    resetN = 1'b1;
  endtask

  // Monitor: per-cycle status compare plus an event pop on every new presentation.
  initial begin
    bit      prevV [NDUT];
    int      curCode [NDUT];
    status_t s;
    event_t  e;
    int      idx;
    for (int k = 0; k < NDUT; k++) begin
      prevV[k]   = 1'b0;
      curCode[k] = 0;
    end
    forever begin
      @(negedge clk);
      while (statQ.size() > 0 && statQ[0].cyc == cyc) begin
        s = statQ.pop_front();
        check($sformatf("valid d%0d", s.dut), int'(evt_valid[s.dut]), int'(s.valid));
        check($sformatf("drop_count d%0d", s.dut), int'(drop_count[s.dut]), s.drops);
        check($sformatf("overrun d%0d", s.dut), int'(overrun[s.dut]), int'(s.ovr));
        check($sformatf("busy d%0d", s.dut), int'(busy[s.dut]), int'(s.busy));
      end
      for (int k = 0; k < NDUT; k++) begin
        if (evt_valid[k] && !prevV[k]) begin
          idx = -1;
          for (int j = 0; j < evQ.size(); j++) begin
            if (evQ[j].dut == k) begin
              idx = j;
              break;
            end
          end
          if (idx < 0) begin
            check($sformatf("unexpected_event d%0d", k), int'(evt_code[k]), 0);
            curCode[k] = 0;
          end else begin
            e = evQ[idx];
            evQ.delete(idx);
            check($sformatf("event_code d%0d", k), int'(evt_code[k]), e.code);
            check($sformatf("event_cycle d%0d", k), cyc, e.cyc);
            curCode[k] = e.code;
          end
        end else if (evt_valid[k]) begin
          check($sformatf("code_hold d%0d", k), int'(evt_code[k]), curCode[k]);
        end else begin
          check($sformatf("code_idle d%0d", k), int'(evt_code[k]), 0);
        end
        prevV[k] = evt_valid[k];
      end
    end
  end

  initial begin
    bit [7:1] p;
    for (int k = 0; k < NDUT; k++) mdl[k] = '{default: 0};
    repeat (3) @(posedge clk);
    #1;
    resetN = 1'b1;
    idle(2, 1'b0);

    // Single SPRING event, acked on its first valid cycle.
    step(1'b0, SPRING, 1'b0);
    step(1'b1, '0, 1'b0);
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b1);
    idle(6, 1'b0);

    // Priority ordering with immediate ack.
    step(1'b0, OBAD | FRAME | FLIP, 1'b1);
    step(1'b1, '0, 1'b1);
    idle(12, 1'b1);

    // Pulse coincident with the frame strobe belongs to the next frame.
    step(1'b1, BUMP, 1'b1);
    idle(6, 1'b1);
    step(1'b1, '0, 1'b1);
    idle(8, 1'b1);

    // Overrun with ack held low across the next frame strobe.
    step(1'b0, FLIP | BUMP | SPRING | FRAME, 1'b0);
    step(1'b1, '0, 1'b0);
    idle(3, 1'b0);
    step(1'b0, BUMP | OBAD, 1'b0);
    idle(2, 1'b0);
    step(1'b1, '0, 1'b0);
    idle(4, 1'b0);
    idle(16, 1'b1);

    // BOTTOM ack flushes the remaining bank.
    step(1'b0, BOTTOM | SPRING, 1'b1);
    step(1'b1, '0, 1'b1);
    idle(10, 1'b1);

    // Randomised frames, pulses and acks.
    for (int i = 0; i < 1500; i++) begin
      for (int b = 1; b <= 7; b++) p[b] = ($urandom_range(15) == 0);
      step($urandom_range(11) == 0, p, $urandom_range(1) == 1);
    end
    idle(20, 1'b1);

    // Saturate the drop counter, then reset while an event is in flight.
    for (int f = 0; f < 45; f++) begin
      step(1'b0, OBAD | OGOOD | FRAME | SPRING | BUMP | FLIP | BOTTOM, 1'b0);
      step(1'b1, '0, 1'b0);
      idle(3, 1'b0);
    end
    idle(2, 1'b0);
    doReset();
    idle(6, 1'b1);
    step(1'b0, FLIP, 1'b1);
    step(1'b1, '0, 1'b1);
    idle(20, 1'b1);

    @(posedge clk);
    #1;
    for (int k = 0; k < NDUT; k++) begin
      idx_loop: begin
        int left;
        left = 0;
        for (int j = 0; j < evQ.size(); j++) if (evQ[j].dut == k) left++;
        check($sformatf("events_left d%0d", k), left, 0);
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/collision_event_arbiter.md
# collision_event_arbiter

Serialises the per-frame collision pulses produced by the collision detector into a single prioritised event stream for the ball-physics and score units. Pulses are captured during the pixel scan of one frame, transferred to a dispatch bank at `startOfFrame`, then presented one at a time over a valid/ack handshake. Events not served before the next `startOfFrame` are dropped and counted.

## Interface
Parameters:
- `GAP_CYCLES`, default 2: idle cycles inserted after each acknowledged event (0..15).

Ports:
- `clk`  in  1  system clock.
- `resetN`  in  1  reset, asynchronous, active-low.
- `startOfFrame`  in  1  one-cycle frame boundary strobe.
- `colBottom`, `colFlipper`, `colBumper`, `colSpring`, `colFrame`, `colObstacleGood`, `colObstacleBad`  in  1 each  collision pulses, any cycle, any combination.
- `evt_ack`  in  1  consumer accepts the presented event.
- `evt_valid`  out  1  event presented.
- `evt_code`  out  3  event code; 0 when `evt_valid` is low.
- `drop_count`  out  8  saturating count of dropped events.
- `overrun`  out  1  one-cycle pulse when at least one event is dropped.
- `busy`  out  1  dispatch bank non-empty, or FSM not in IDLE.

## Operation
- Codes and priority, highest first: BOTTOM=1, FLIPPER=2, BUMPER=3, SPRING=4, FRAME=5, OBST_GOOD=6, OBST_BAD=7. The lowest set code is served first.
- Capture bank `cap[7:1]`:
  - Normal cycle: `cap <= cap | pulses`.
  - `startOfFrame` cycle: `cap <= pulses`. A pulse coincident with `startOfFrame` belongs to the new frame.
  - Repeated pulses of one type within a frame collapse to a single event.
- Dispatch bank `disp[7:1]`:
  - On `startOfFrame`: `disp <= cap`.
  - On `startOfFrame`, if the old `disp` is non-zero: `drop_count += popcount(old disp)`, saturating at 255, and `overrun` pulses for one cycle.
- FSM states: IDLE, PRESENT, GAP.
- IDLE:
  - If `disp != 0` and `startOfFrame` is low, go to PRESENT. In the same edge, latch `evt_code` to the highest-priority set bit and clear that bit in `disp`.
  - In the `startOfFrame` cycle, IDLE never launches.
- PRESENT:
  - `evt_valid` = 1 and `evt_code` is held stable until `evt_ack` is sampled high.
  - On ack: go to GAP with counter = `GAP_CYCLES`, or to IDLE if `GAP_CYCLES` = 0.
  - If the acked code is BOTTOM, `disp` is cleared. This is not counted as a drop.
- `startOfFrame` during PRESENT: the in-flight event is never withdrawn and keeps waiting for ack. Only the bits still in `disp` are dropped.
- GAP: `evt_valid` = 0. Decrement the counter each cycle; go to IDLE after `GAP_CYCLES` cycles.
- `evt_ack` is ignored outside PRESENT.
- Reset values: `cap` = 0, `disp` = 0, state = IDLE, `evt_valid` = 0, `evt_code` = 0, `drop_count` = 0, `overrun` = 0, `busy` = 0.
- Asserting `resetN` mid-operation clears everything immediately, including an in-flight event.

## Timing
- `startOfFrame` high in cycle T: `disp` is valid in T+1, and the first `evt_valid` is high in T+2.
- `evt_ack` high in cycle A (in PRESENT):
  - `evt_valid` is low from A+1.
  - GAP occupies A+1..A+G; IDLE is A+G+1; the next event is presented at A+G+2.
  - With G = 0: IDLE at A+1, next event at A+2.
- `evt_ack` asserted in the first presented cycle is legal; minimum residency in PRESENT is 1 cycle.
- `overrun` and `drop_count` update on the edge that samples `startOfFrame`, and are visible in T+1.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- **Single event, G=2:**
  - Stimulus: `colSpring` pulse in frame N, `startOfFrame` at T, ack on the first valid cycle.
  - Response: `evt_valid` high at T+2 with `evt_code` = 4; valid low from T+3; `busy` low at T+5.
- **Priority ordering, G=0:**
  - Stimulus: `colObstacleBad`, `colFrame` and `colFlipper` all pulse in the same frame; ack is immediate each time.
  - Response: codes 2, 5, 7 presented at T+2, T+4, T+6.
- **Coincident pulse:**
  - Stimulus: `colBumper` pulses in the same cycle as `startOfFrame`.
  - Response: no event after that boundary; code 3 is presented after the following `startOfFrame`.
- **Overrun with held ack:**
  - Stimulus: frame N captures 4 events, and `evt_ack` is held low across the next `startOfFrame`.
  - Response: code 2 (or the first code) stays valid; `drop_count` = 3 and `overrun` pulses once; the new bank is served after the ack.
- **BOTTOM flush:**
  - Stimulus: `colBottom` and `colSpring` in one frame; ack BOTTOM.
  - Response: code 1 is presented, then no further event; `drop_count` is unchanged.
- **Saturation and reset:**
  - Stimulus: force 260 drops, then pulse `resetN` low while PRESENT.
  - Response: `drop_count` holds at 255; on reset all outputs go to 0 immediately, and no event is presented afterwards until a new capture.
